// File: rtl/multiplicador_seq_if.sv
// Handshake/operand bundle for the sequential multiplier: start request,
// operands, Idle/Done status and the product/accumulator view.
interface multiplicador_seq_if #(
  parameter int WIDTH = 16
);
  logic                 St;
  logic [WIDTH-1:0]     Multiplicando;
  logic [WIDTH-1:0]     Multiplicador;
  logic                 Idle;
  logic                 Done;
  logic [2*WIDTH-1:0]   Produto;

  modport master (
    output St, Multiplicando, Multiplicador,
    input  Idle, Done, Produto
  );

  modport slave (
    input  St, Multiplicando, Multiplicador,
    output Idle, Done, Produto
  );
endinterface

// File: rtl/multiplicador_seq.sv
// Radix-2 shift-and-add unsigned WIDTHxWIDTH multiplier, one multiplier bit per clock.
// Optional macro MULT_DONE_HOLD_EN: hold DONE (Done=1, Idle=1) until the next start.
module multiplicador_seq #(
  parameter int WIDTH = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  multiplicador_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             start;
  logic             idle;
  logic             done;
  logic [WIDTH:0]   sum;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    idle    = 1'b0;
    done    = 1'b0;
    sum     = '0;

    unique case (state_q)
      S_IDLE: begin
        idle  = 1'b1;
        start = bus.St;
      end

      S_CALC: begin
        // acc_q[AW-1] is always 0 on entry to a step, so the upper slice
        // including it equals {0, ACC[2W-1:W]}.
        sum   = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_d = {sum, acc_q[WIDTH-1:0]} >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done = 1'b1;
`ifdef MULT_DONE_HOLD_EN
        idle  = 1'b1;
        start = bus.St;
`else
        state_d = S_IDLE;
`endif
      end

      default: state_d = S_IDLE;
    endcase

    // Operand load shared by IDLE and (optionally) held DONE.
    if (start) begin
      mcand_d = bus.Multiplicando;
      acc_d   = {1'b0, {WIDTH{1'b0}}, bus.Multiplicador};
      cnt_d   = '0;
      state_d = S_CALC;
    end
  end

  // NOTE: all datapath registers are reset so an aborted operation leaves Produto at 0.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Idle    = idle;
  assign bus.Done    = done;
  assign bus.Produto = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench for multiplicador_seq: directed boundary cases plus
// random operand pairs against an arithmetic reference product.
module tb_multiplicador_seq;

  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  multiplicador_seq_if #(.WIDTH(WIDTH)) bus ();

  multiplicador_seq #(.WIDTH(WIDTH)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint unsigned pa, pb;
    pa = longint'(a);
    pb = longint'(b);
    return 64'(pa * pb);
  endfunction

  // Start one operation (St high for 'hold' sampled cycles), wait for Done,
  // then check latency, product, and the state one cycle after Done.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int hold, input string tag);
    int lat;
    logic [63:0] exp;
    exp = ref_mul(a, b);
    lat = 0;
    @(negedge clk);
    bus.St            = 1'b1;
    bus.Multiplicando = a;
    bus.Multiplicador = b;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check({tag, "_idle_drop"}, 64'(bus.Idle), 64'(0));
      if (cyc == hold) begin
        bus.St            = 1'b0;
        bus.Multiplicando = WIDTH'($urandom);
        bus.Multiplicador = WIDTH'($urandom);
      end
      if (bus.Done) begin
        lat = cyc;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(17));
    check({tag, "_product"}, 64'(bus.Produto), exp);
    @(negedge clk);
    check({tag, "_idle_after"}, 64'(bus.Idle), 64'(1));
`ifdef MULT_DONE_HOLD_EN
    check({tag, "_done_after"}, 64'(bus.Done), 64'(1));
`else
    check({tag, "_done_after"}, 64'(bus.Done), 64'(0));
`endif
    check({tag, "_hold"}, 64'(bus.Produto), exp);
  endtask

  initial begin
    int period;
    int n_done;
    logic exp_done;
    logic exp_idle;

    rst_n             = 1'b0;
    bus.St            = 1'b0;
    bus.Multiplicando = '0;
    bus.Multiplicador = '0;

    // Reset, then idle with St low.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle", 64'(bus.Idle), 64'(1));
    check("rst_done", 64'(bus.Done), 64'(0));
    check("rst_prod", 64'(bus.Produto), 64'(0));
    bus.Multiplicando = 16'hABCD;
    bus.Multiplicador = 16'h1234;
    repeat (10) @(negedge clk);
    check("quiet_idle", 64'(bus.Idle), 64'(1));
    check("quiet_done", 64'(bus.Done), 64'(0));
    check("quiet_prod", 64'(bus.Produto), 64'(0));

    // Basic product and hold.
    run_op(16'd5, 16'd3, 1, "p5x3");
    repeat (5) @(negedge clk);
    check("p5x3_held", 64'(bus.Produto), 64'(15));

    // Top-of-range sweep, St held two cycles each.
    for (int i = 65530; i <= 65535; i++) begin
      for (int j = 65530; j <= 65535; j++) begin
        run_op(WIDTH'(i), WIDTH'(j), 2, $sformatf("sweep_%0dx%0d", i, j));
      end
    end

    // Zero operands still take the full iteration count.
    run_op(16'd0, 16'hFFFF, 1, "zero_a");
    run_op(16'hFFFF, 16'd0, 1, "zero_b");

    // Random pairs.
    for (int k = 0; k < 20; k++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1 + (k % 2), $sformatf("rand%0d", k));
    end

    // St held high: back-to-back operations on 2*7.
`ifdef MULT_DONE_HOLD_EN
    period = 17;
`else
    period = 18;
`endif
    n_done = 0;
    @(negedge clk);
    bus.St            = 1'b1;
    bus.Multiplicando = 16'd2;
    bus.Multiplicador = 16'd7;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      exp_done = (cyc >= 17) && (((cyc - 17) % period) == 0);
`ifdef MULT_DONE_HOLD_EN
      exp_idle = exp_done;
`else
      exp_idle = (cyc >= 18) && (((cyc - 18) % period) == 0);
`endif
      check($sformatf("b2b_done_c%0d", cyc), 64'(bus.Done), 64'(exp_done));
      check($sformatf("b2b_idle_c%0d", cyc), 64'(bus.Idle), 64'(exp_idle));
      if (bus.Done) begin
        n_done++;
        check($sformatf("b2b_prod_c%0d", cyc), 64'(bus.Produto), 64'(14));
      end
    end
    check("b2b_count", 64'(n_done), 64'((60 - 17) / period + 1));
    bus.St = 1'b0;
    repeat (40) @(negedge clk);

    // Reset asserted mid-calculation aborts immediately.
    @(negedge clk);
    bus.St            = 1'b1;
    bus.Multiplicando = 16'h1234;
    bus.Multiplicador = 16'h5678;
    @(negedge clk);
    bus.St = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy", 64'(bus.Idle), 64'(0));
    rst_n = 1'b0;
    #1;
    check("abort_idle", 64'(bus.Idle), 64'(1));
    check("abort_done", 64'(bus.Done), 64'(0));
    check("abort_prod", 64'(bus.Produto), 64'(0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort_nodone%0d", c), 64'(bus.Done), 64'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd100, 16'd200, 1, "after_abort");
    check("after_abort_val", 64'(bus.Produto), 64'(20000));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
